xbar_slv_rd_resp: RTL and testbench
===================================

Name: xbar_slv_rd_resp

Overview:
- Responder at the slave end of the crossbar read channel. It accepts the per-slave read request, valid, address, select and last signals driven by the crossbar slave-side read arbiter.
- It reads a synchronous SRAM-style memory with parameterised latency and returns byte-masked data with a one-cycle Ready pulse per beat.
- It is instantiated once per readable slave, for example the packet buffer or the descriptor RAM.

Parameters:
- AW, 12, read address width.
- DW, 32, data width; must equal 8*SW.
- SW, 4, byte-select width.
- DEPTH, 1024, number of valid memory words; an address >= DEPTH is out of range.
- RD_LAT, 1, memory read latency in cycles, legal range 1..4.
- ERR_DATA, 32'hDEAD_BEEF, data returned for an out-of-range beat.

Ports:
- iClk  in  1  clock; single clock domain.
- iRst  in  1  reset, synchronous, active-high.
- iRdReq  in  1  burst ownership from the crossbar; held high for the whole burst.
- iRdValid  in  1  beat address valid; held until oRdReady.
- iRdAddr  in  AW  beat word address.
- iRdSel  in  SW  byte select for the beat.
- iRdLast  in  1  marks the final beat of the burst.
- oRdReady  out  1  beat-complete pulse; oRdData is valid in the same cycle.
- oRdData  out  DW  returned data with unselected bytes forced to 0.
- oMemRdEn  out  1  memory read strobe.
- oMemRdAddr  out  AW  memory read address.
- iMemRdData  in  DW  memory read data, valid RD_LAT cycles after oMemRdEn.
- oBusy  out  1  high whenever the FSM is not in IDLE.
- oErr  out  1  one-cycle pulse, coincident with oRdReady, on an out-of-range beat.
- oBurstDone  out  1  one-cycle pulse, coincident with oRdReady, on the last beat.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; internal address, select, last, data and counter registers cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE, beat accepted: when iRdReq && iRdValid in cycle T:
  - capture iRdAddr, iRdSel and iRdLast into registers.
  - In range: oMemRdEn=1 and oMemRdAddr=iRdAddr combinationally in T; latency counter loads RD_LAT-1; go to WAIT.
  - Out of range: oMemRdEn stays 0; data register loads ERR_DATA; error flag set; go directly to RESP.
- IDLE, ignored input: iRdValid with iRdReq low is ignored.
- WAIT:
  - counter != 0: decrement.
  - counter == 0: capture iMemRdData into the data register; go to RESP.
  - If iRdReq is low in any WAIT cycle, set the abort flag. The memory read still completes, but its result is discarded.
- RESP, normal: oRdReady=1 for exactly one cycle, but only if iRdReq is high and abort is clear.
  - oRdData byte k = data register byte k if the captured sel[k] is 1, else 0.
  - oBurstDone = oRdReady && captured last.
  - oErr = oRdReady && error flag.
  - Always return to IDLE next cycle; clear abort and error.
- RESP, suppressed: when abort is set or iRdReq is low, oRdReady, oRdData, oErr and oBurstDone stay 0.
- oRdData is 0 in every cycle where oRdReady is 0.
- Latency: in-range beat has oRdReady at T+RD_LAT+1; out-of-range beat has oRdReady at T+1.
  - Throughput is one beat per RD_LAT+2 cycles; the next beat can be accepted in the cycle after RESP.
- Master contract: the master changes iRdAddr only after oRdReady. The address captured in T is used even if the inputs change during WAIT.
- Reset mid-operation (WAIT or RESP): the next cycle is IDLE with all outputs 0, and no Ready pulse is emitted for the pending beat.
- Range check: iRdAddr >= DEPTH, evaluated unsigned at full AW width.

Decomposition:
- Shared header xbar_defs.vh holds: FSM state encodings (2-bit), the ERR_DATA default, and the RD_LAT legal-range checks.
- One sub-module is natural: xbar_sel_mask, a combinational SW-bit select to DW-bit byte-mask expander, reusable by the write path.
- The latency counter and FSM stay inline.

Test Plan (DW=32, SW=4, AW=12, DEPTH=1024, RD_LAT=1 unless stated):
1. Single in-range beat: Req=1, Valid=1, Addr=0x010, Sel=4'hF, Last=1 at T; mem[0x010]=32'hA5A51234.
   -> oMemRdEn=1 with oMemRdAddr=0x010 at T; oRdReady=1, oRdData=32'hA5A51234 and oBurstDone=1 at T+2; oBusy high at T+1..T+2.
2. Byte masking: Sel=4'b0101, mem=32'hAABBCCDD.
   -> oRdData=32'h00BB00DD at Ready; oRdData=0 in all other cycles.
3. Four-beat burst: addresses 0x100..0x103, Last on beat 4.
   -> four Ready pulses 3 cycles apart; oBurstDone only on the 4th; oErr never asserts.
4. Out-of-range beat: Addr=0x400 at T.
   -> oMemRdEn never asserts; oRdReady=1, oRdData=32'hDEADBEEF and oErr=1 at T+1.
5. Request dropped: Req deasserted at T+1 (in WAIT).
   -> no oRdReady, oErr or oBurstDone; oBusy=0 at T+3.
6. RD_LAT=3, addr 0x020: Ready at T+4. Repeat with iRst pulsed at T+2.
   -> all outputs 0 from T+3; no Ready pulse; a fresh beat at T+5 completes normally at T+9.

Source files
------------

// File: rtl/xbar_slv_rd_resp_pkg.sv
// Shared types and defaults for the crossbar slave read responder:
// FSM encoding, default bus widths and the out-of-range data pattern.
package xbar_slv_rd_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 32;
    localparam int SW_DEF = 4;

    // Supported memory read latency window; the latency counter is 2 bits wide.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/xbar_slv_rd_resp_if.sv
// Read-beat handshake and SRAM read port seen by one slave responder.
interface xbar_slv_rd_resp_if
    import xbar_slv_rd_resp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
);
    logic          iRdReq;
    logic          iRdValid;
    logic [AW-1:0] iRdAddr;
    logic [SW-1:0] iRdSel;
    logic          iRdLast;
    logic          oRdReady;
    logic [DW-1:0] oRdData;
    logic          oMemRdEn;
    logic [AW-1:0] oMemRdAddr;
    logic [DW-1:0] iMemRdData;
    logic          oBusy;
    logic          oErr;
    logic          oBurstDone;

    modport slave (
        input  iRdReq, iRdValid, iRdAddr, iRdSel, iRdLast, iMemRdData,
        output oRdReady, oRdData, oMemRdEn, oMemRdAddr, oBusy, oErr, oBurstDone
    );

    modport master (
        output iRdReq, iRdValid, iRdAddr, iRdSel, iRdLast, iMemRdData,
        input  oRdReady, oRdData, oMemRdEn, oMemRdAddr, oBusy, oErr, oBurstDone
    );
endinterface

// File: rtl/xbar_slv_rd_resp_sel_mask.sv
// Expands an SW-bit byte select into a DW-bit byte mask; shared with the write path.
module xbar_sel_mask #(
    parameter int SW = 4,
    parameter int DW = 32
) (
    input  logic [SW-1:0] sel_i,
    output logic [DW-1:0] mask_o
);
    for (genvar k = 0; k < SW; k++) begin : g_byte
        assign mask_o[8*k +: 8] = {8{sel_i[k]}};
    end
endmodule

// File: rtl/xbar_slv_rd_resp.sv
// Slave-side read responder: one SRAM read per beat, byte-masked data and a
// single-cycle ready pulse; out-of-range beats return ERR_DATA without a memory access.
module xbar_slv_rd_resp
    import xbar_slv_rd_resp_pkg::*;
#(
    parameter int          AW       = 12,
    parameter int          DW       = 32,
    parameter int          SW       = 4,
    parameter int          DEPTH    = 1024,
    parameter int          RD_LAT   = 1,
    parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
    input  logic              iClk,
    input  logic              iRst,
    xbar_slv_rd_resp_if.slave bus
);
    localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [1:0]  LAT_LOAD_C = 2'(RD_LAT - 1);

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;

    logic          in_range_s;
    logic          mem_en_s;
    logic          ready_s;
    logic [DW-1:0] mask_s;

    assign in_range_s = ({1'b0, bus.iRdAddr} < DEPTH_C);

    xbar_sel_mask #(.SW(SW), .DW(DW)) u_sel_mask (
        .sel_i  (sel_q),
        .mask_o (mask_s)
    );

    // State and beat-context registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic, memory strobe and ready decision.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        last_d   = last_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        abort_d  = abort_q;
        mem_en_s = 1'b0;
        ready_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iRdReq && bus.iRdValid) begin
                    addr_d  = bus.iRdAddr;
                    sel_d   = bus.iRdSel;
                    last_d  = bus.iRdLast;
                    abort_d = 1'b0;
                    if (in_range_s) begin
                        mem_en_s = 1'b1;
                        cnt_d    = LAT_LOAD_C;
                        err_d    = 1'b0;
                        state_d  = ST_WAIT;
                    end else begin
                        data_d  = ERR_DATA;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A dropped request still lets the SRAM read finish; only the response is lost.
                if (!bus.iRdReq) begin
                    abort_d = 1'b1;
                end else begin
                    abort_d = abort_q;
                end
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    data_d  = bus.iMemRdData;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ready_s = bus.iRdReq && !abort_q;
                abort_d = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.oRdReady   = ready_s && !iRst;
    assign bus.oRdData    = bus.oRdReady ? (data_q & mask_s) : '0;
    assign bus.oErr       = bus.oRdReady && err_q;
    assign bus.oBurstDone = bus.oRdReady && last_q;
    assign bus.oMemRdEn   = mem_en_s && !iRst;
    assign bus.oMemRdAddr = bus.oMemRdEn ? bus.iRdAddr : '0;
    assign bus.oBusy      = (state_q != ST_IDLE) && !iRst;

endmodule

// File: tb/tb_xbar_slv_rd_resp.sv
// Scoreboard bench: directed and random beats on an RD_LAT=1 responder, plus
// latency/reset checks on an RD_LAT=3 responder sharing the same memory image.
module tb_xbar_slv_rd_resp;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        done;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mem [1024];
    exp_t        sb_q [$];
    logic [11:0] pa;
    logic [11:0] pb [3];

    xbar_slv_rd_resp_if #(.AW(12), .DW(32), .SW(4)) ifa ();
    xbar_slv_rd_resp_if #(.AW(12), .DW(32), .SW(4)) ifb ();

    xbar_slv_rd_resp #(.RD_LAT(1)) u_dut_a (.iClk(clk), .iRst(rst_a), .bus(ifa));
    xbar_slv_rd_resp #(.RD_LAT(3)) u_dut_b (.iClk(clk), .iRst(rst_b), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM models: read address sampled with the strobe, data RD_LAT cycles later.
    always @(posedge clk) begin
        pa    <= ifa.oMemRdEn ? ifa.oMemRdAddr : 12'hFFF;
        pb[0] <= ifb.oMemRdEn ? ifb.oMemRdAddr : 12'hFFF;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign ifa.iMemRdData = (pa    < 12'd1024) ? mem[pa[9:0]]    : 32'h0BAD_0BAD;
    assign ifb.iMemRdData = (pb[2] < 12'd1024) ? mem[pb[2][9:0]] : 32'h0BAD_0BAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_data(input logic [11:0] addr, input logic [3:0] sel);
        logic [31:0] raw;
        logic [31:0] res;
        raw = (addr >= 12'd1024) ? 32'hDEAD_BEEF : mem[addr[9:0]];
        res = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = raw[8*k +: 8];
        end
        return res;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_a) begin
            if (ifa.oRdReady) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rd_data", ifa.oRdData, e.data);
                    chk("err", {31'd0, ifa.oErr}, {31'd0, e.err});
                    chk("burst_done", {31'd0, ifa.oBurstDone}, {31'd0, e.done});
                    chk("ready_cycle", cyc, e.cyc);
                end
            end else begin
                chk("quiet_outputs", {ifa.oRdData[31:2], ifa.oErr, ifa.oBurstDone}, 32'd0);
            end
        end
    end

    task automatic beat_a(input logic [11:0] addr, input logic [3:0] sel,
                          input logic last, input logic drop);
        int   t0;
        bit   seen;
        exp_t e;
        logic oor;
        @(negedge clk); #2;
        ifa.iRdReq   = 1'b1;
        ifa.iRdValid = 1'b1;
        ifa.iRdAddr  = addr;
        ifa.iRdSel   = sel;
        ifa.iRdLast  = last;
        t0  = cyc;
        oor = (addr >= 12'd1024);
        #1;
        chk("mem_rd_en", {31'd0, ifa.oMemRdEn}, {31'd0, !oor});
        if (!oor) chk("mem_rd_addr", {20'd0, ifa.oMemRdAddr}, {20'd0, addr});
        if (drop) begin
            @(negedge clk); #2;
            ifa.iRdReq   = 1'b0;
            ifa.iRdValid = 1'b0;
            @(negedge clk); #2;
            @(negedge clk); #2;
            chk("drop_busy", {31'd0, ifa.oBusy}, 32'd0);
        end else begin
            e.data = ref_data(addr, sel);
            e.err  = oor;
            e.done = last;
            e.cyc  = t0 + (oor ? 1 : 2);
            sb_q.push_back(e);
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge clk); #2;
                chk("busy", {31'd0, ifa.oBusy}, 32'd1);
                if (ifa.oRdReady) seen = 1'b1;
            end
            if (!seen) chk("ready_timeout", 32'd0, 32'd1);
            ifa.iRdValid = 1'b0;
            if (last) ifa.iRdReq = 1'b0;
        end
    endtask

    task automatic check_b_quiet(input string name);
        chk(name, {ifb.oRdData[31:7], ifb.oRdReady, ifb.oErr, ifb.oBurstDone,
                   ifb.oBusy, ifb.oMemRdEn, |ifb.oMemRdAddr, 1'b0}, 32'd0);
    endtask

    task automatic drive_b(input logic [11:0] addr);
        ifb.iRdReq   = 1'b1;
        ifb.iRdValid = 1'b1;
        ifb.iRdAddr  = addr;
        ifb.iRdSel   = 4'hF;
        ifb.iRdLast  = 1'b1;
    endtask

    task automatic wait_ready_b(input int t0, input int lat, input logic [11:0] addr, input string name);
        int seen_cyc;
        seen_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #2;
            if (ifb.oRdReady && seen_cyc < 0) begin
                seen_cyc = cyc;
                chk({name, "_data"}, ifb.oRdData, mem[addr[9:0]]);
                ifb.iRdValid = 1'b0;
                ifb.iRdReq   = 1'b0;
            end
        end
        chk({name, "_cycle"}, seen_cyc, t0 + lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[12'h010] = 32'hA5A5_1234;
        mem[12'h040] = 32'hAABB_CCDD;
        ifa.iRdReq = 1'b0; ifa.iRdValid = 1'b0; ifa.iRdAddr = '0; ifa.iRdSel = '0; ifa.iRdLast = 1'b0;
        ifb.iRdReq = 1'b0; ifb.iRdValid = 1'b0; ifb.iRdAddr = '0; ifb.iRdSel = '0; ifb.iRdLast = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk); #2;
        chk("reset_a", {ifa.oRdData[31:5], ifa.oRdReady, ifa.oErr, ifa.oBurstDone,
                        ifa.oBusy, ifa.oMemRdEn}, 32'd0);
        check_b_quiet("reset_b");

        // Valid without request must be ignored.
        ifa.iRdValid = 1'b1;
        ifa.iRdAddr  = 12'h010;
        #1;
        chk("no_req_mem_en", {31'd0, ifa.oMemRdEn}, 32'd0);
        @(negedge clk); #2;
        chk("no_req_busy", {31'd0, ifa.oBusy}, 32'd0);
        ifa.iRdValid = 1'b0;

        beat_a(12'h010, 4'hF, 1'b1, 1'b0);
        beat_a(12'h040, 4'b0101, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat_a(12'h100 + 12'(i), 4'hF, (i == 3), 1'b0);
        beat_a(12'h400, 4'hF, 1'b1, 1'b0);
        beat_a(12'h3FF, 4'b1010, 1'b0, 1'b0);
        beat_a(12'hFFF, 4'b0011, 1'b1, 1'b0);
        beat_a(12'h055, 4'hF, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [11:0] a;
            logic        oor;
            oor = ($urandom_range(0, 3) == 0);
            a   = oor ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 1023));
            beat_a(a, 4'($urandom), 1'($urandom), !oor && ($urandom_range(0, 7) == 0));
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        // RD_LAT=3 responder: nominal latency.
        mem[12'h020] = 32'h1357_9BDF;
        mem[12'h021] = 32'h2468_ACE0;
        @(negedge clk); #2;
        drive_b(12'h020);
        t0 = cyc;
        wait_ready_b(t0, 4, 12'h020, "lat3");

        // Reset during WAIT drops the pending beat; a fresh beat then runs normally.
        @(negedge clk); #2;
        drive_b(12'h020);
        t0 = cyc;
        @(negedge clk); #2;
        @(negedge clk); #2;
        rst_b        = 1'b1;
        ifb.iRdValid = 1'b0;
        @(negedge clk); #2;
        check_b_quiet("rst_t3");
        rst_b = 1'b0;
        @(negedge clk); #2;
        check_b_quiet("rst_t4");
        @(negedge clk); #2;
        chk("rst_fresh_cycle", cyc, t0 + 5);
        drive_b(12'h021);
        wait_ready_b(t0 + 5, 4, 12'h021, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
